// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions for the write-back stage: load encodings, FSM states,
// the latched load request, and the load legality check.
package wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic [4:0] rd;
    logic       reg_write;
  } load_req_t;

  // Unknown funct3 codes are treated the same as misaligned accesses.
  function automatic logic load_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake, data-memory read return and register-file write port.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_reg_write;
  logic        mem_is_load;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [4:0]  mem_rd_index;
  logic [31:0] mem_alu_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  rd_index;
  logic        load_err;

  modport master (
    output mem_valid, mem_reg_write, mem_is_load, mem_funct3, mem_addr_lo,
           mem_rd_index, mem_alu_result, dmem_rvalid, dmem_rdata,
    input  mem_ready, wb_en, wb_data, rd_index, load_err
  );

  modport slave (
    input  mem_valid, mem_reg_write, mem_is_load, mem_funct3, mem_addr_lo,
           mem_rd_index, mem_alu_result, dmem_rvalid, dmem_rdata,
    output mem_ready, wb_en, wb_data, rd_index, load_err
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks the addressed byte/halfword of a
// little-endian word and sign- or zero-extends it according to funct3.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers ALU results directly and waits for data-memory
// returns on loads, aborting misaligned/illegal loads and loads that time out.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state, state_nxt;
  load_req_t        ld, ld_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        wb_en_q, wb_en_nxt;
  logic        load_err_q, load_err_nxt;
  logic [31:0] wb_data_q, wb_data_nxt;
  logic [4:0]  rd_q, rd_nxt;

  logic        accept;
  logic        acc_bad;
  logic        timeout;
  logic [31:0] ld_data;

  assign bus.mem_ready = (state == ST_IDLE);
  assign bus.wb_en     = wb_en_q;
  assign bus.load_err  = load_err_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.rd_index  = rd_q;

  assign accept  = bus.mem_valid && bus.mem_ready;
  assign acc_bad = load_misaligned(bus.mem_funct3, bus.mem_addr_lo);
  assign timeout = !bus.dmem_rvalid && (cnt == CNT_LAST);

  load_align u_align (
    .funct3  (ld.funct3),
    .addr_lo (ld.addr_lo),
    .rdata   (bus.dmem_rdata),
    .data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (accept && bus.mem_is_load && !acc_bad) state_nxt = ST_WAIT_LOAD;
      ST_WAIT_LOAD:
        if (bus.dmem_rvalid || timeout) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the output/datapath registers; outputs hold by default.
  always_comb begin
    wb_en_nxt    = 1'b0;
    load_err_nxt = 1'b0;
    wb_data_nxt  = wb_data_q;
    rd_nxt       = rd_q;
    cnt_nxt      = cnt;
    ld_nxt       = ld;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!bus.mem_is_load) begin
            wb_en_nxt   = bus.mem_reg_write && (bus.mem_rd_index != 5'd0);
            wb_data_nxt = bus.mem_alu_result;
            rd_nxt      = bus.mem_rd_index;
          end else if (acc_bad) begin
            load_err_nxt = 1'b1;
          end else begin
            ld_nxt  = '{funct3:    bus.mem_funct3,
                        addr_lo:   bus.mem_addr_lo,
                        rd:        bus.mem_rd_index,
                        reg_write: bus.mem_reg_write};
            cnt_nxt = '0;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (bus.dmem_rvalid) begin
          wb_en_nxt   = ld.reg_write && (ld.rd != 5'd0);
          wb_data_nxt = ld_data;
          rd_nxt      = ld.rd;
        end else if (timeout) begin
          load_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      ld         <= '0;
      wb_en_q    <= 1'b0;
      load_err_q <= 1'b0;
      wb_data_q  <= '0;
      rd_q       <= '0;
    end else begin
      cnt        <= cnt_nxt;
      ld         <= ld_nxt;
      wb_en_q    <= wb_en_nxt;
      load_err_q <= load_err_nxt;
      wb_data_q  <= wb_data_nxt;
      rd_q       <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level model.
module tb_wb_stage;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] exp_data = '0;
  logic [4:0]  exp_rd = '0;

  wb_stage_if bus();

  wb_stage #(.LOAD_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: which loads are rejected at accept.
  function automatic bit ref_bad(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (a % 2) != 0;
      3'b010:         return a != 0;
      default:        return 1'b1;
    endcase
  endfunction

  // Model: loaded value by shifting and masking, sign handled arithmetically.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    longint v;
    v = longint'(w >> (8 * int'(a)));
    case (f3)
      3'b000: begin v = v % 256;   if (v > 127)   v -= 256;   end
      3'b100:       v = v % 256;
      3'b001: begin v = v % 65536; if (v > 32767) v -= 65536; end
      3'b101:       v = v % 65536;
      default:      v = longint'(w);
    endcase
    return 32'(v);
  endfunction

  task automatic idle_check();
    bus.mem_valid = 1'b0;
    bus.dmem_rvalid = 1'($urandom % 2);
    bus.dmem_rdata = $urandom;
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("idle_wb_en", bus.wb_en, 0);
    chk("idle_err", bus.load_err, 0);
    chk("idle_data_hold", bus.wb_data, exp_data);
    chk("idle_rd_hold", bus.rd_index, exp_rd);
    chk("idle_ready", bus.mem_ready, 1);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] d, input logic rw);
    chk("alu_ready", bus.mem_ready, 1);
    bus.mem_valid = 1'b1;
    bus.mem_is_load = 1'b0;
    bus.mem_reg_write = rw;
    bus.mem_rd_index = rd;
    bus.mem_alu_result = d;
    bus.mem_funct3 = 3'($urandom);
    bus.mem_addr_lo = 2'($urandom);
    bus.dmem_rvalid = 1'($urandom % 2);
    bus.dmem_rdata = $urandom;
    tick();
    bus.mem_valid = 1'b0;
    bus.dmem_rvalid = 1'b0;
    exp_data = d;
    exp_rd = rd;
    chk("alu_wb_en", bus.wb_en, 32'(rw && rd != 0));
    chk("alu_data", bus.wb_data, d);
    chk("alu_rd", bus.rd_index, 32'(rd));
    chk("alu_err", bus.load_err, 0);
  endtask

  // waits >= TO means rvalid never comes and the load must time out.
  task automatic load_op(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] rd,
                         input logic rw, input int waits, input logic [31:0] w);
    chk("ld_ready", bus.mem_ready, 1);
    bus.mem_valid = 1'b1;
    bus.mem_is_load = 1'b1;
    bus.mem_funct3 = f3;
    bus.mem_addr_lo = a;
    bus.mem_rd_index = rd;
    bus.mem_reg_write = rw;
    bus.mem_alu_result = $urandom;
    bus.dmem_rvalid = 1'($urandom % 2);
    bus.dmem_rdata = $urandom;
    tick();
    bus.mem_valid = 1'b0;
    bus.dmem_rvalid = 1'b0;
    if (ref_bad(f3, a)) begin
      chk("bad_err", bus.load_err, 1);
      chk("bad_nowr", bus.wb_en, 0);
      chk("bad_ready", bus.mem_ready, 1);
      chk("bad_hold", bus.wb_data, exp_data);
      tick();
      chk("bad_err_single", bus.load_err, 0);
      return;
    end
    chk("ld_busy", bus.mem_ready, 0);
    if (waits >= TO) begin
      for (int i = 1; i < TO; i++) begin
        bus.dmem_rdata = $urandom;
        tick();
        chk("to_wait", {bus.load_err, bus.wb_en, bus.mem_ready}, 0);
      end
      tick();
      chk("to_err", bus.load_err, 1);
      chk("to_nowr", bus.wb_en, 0);
      chk("to_idle", bus.mem_ready, 1);
      chk("to_hold", bus.wb_data, exp_data);
      tick();
      chk("to_err_single", bus.load_err, 0);
      return;
    end
    for (int i = 0; i < waits; i++) begin
      bus.dmem_rdata = $urandom;
      tick();
      chk("ld_wait", {bus.load_err, bus.wb_en, bus.mem_ready}, 0);
    end
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata = w;
    tick();
    bus.dmem_rvalid = 1'b0;
    exp_data = ref_load(f3, a, w);
    exp_rd = rd;
    chk("ld_wb_en", bus.wb_en, 32'(rw && rd != 0));
    chk("ld_data", bus.wb_data, exp_data);
    chk("ld_rd", bus.rd_index, 32'(rd));
    chk("ld_err", bus.load_err, 0);
    chk("ld_done_ready", bus.mem_ready, 1);
  endtask

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_reg_write = 1'b0;
    bus.mem_is_load = 1'b0;
    bus.mem_funct3 = '0;
    bus.mem_addr_lo = '0;
    bus.mem_rd_index = '0;
    bus.mem_alu_result = '0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.mem_ready, 1);
    chk("rst_outs", {bus.wb_en, bus.load_err, bus.rd_index}, 0);
    chk("rst_data", bus.wb_data, 0);
    rst_n = 1'b1;
    chk("rel_ready", bus.mem_ready, 1);

    // Directed scenarios
    alu_op(5'd5, 32'h1234_5678, 1'b1);
    chk("alu_const", bus.wb_data, 32'h1234_5678);
    alu_op(5'd9, 32'hCAFE_F00D, 1'b1);
    alu_op(5'd3, 32'h0BAD_0BAD, 1'b0);
    idle_check();
    load_op(3'b000, 2'd3, 5'd7, 1'b1, 2, 32'h80FF_0000);
    chk("lb_const", bus.wb_data, 32'hFFFF_FF80);
    load_op(3'b100, 2'd3, 5'd7, 1'b1, 2, 32'h80FF_0000);
    chk("lbu_const", bus.wb_data, 32'h0000_0080);
    load_op(3'b001, 2'd2, 5'd8, 1'b1, 1, 32'h8001_0000);
    chk("lh_const", bus.wb_data, 32'hFFFF_8001);
    load_op(3'b010, 2'd1, 5'd8, 1'b1, 0, 32'h0);
    load_op(3'b010, 2'd0, 5'd4, 1'b1, TO, 32'h0);
    load_op(3'b010, 2'd0, 5'd0, 1'b1, 1, 32'hDEAD_BEEF);
    load_op(3'b101, 2'd2, 5'd11, 1'b1, TO - 1, 32'h8001_7FFE);
    idle_check();

    // Reset in the middle of a pending load
    chk("mr_ready", bus.mem_ready, 1);
    bus.mem_valid = 1'b1;
    bus.mem_is_load = 1'b1;
    bus.mem_funct3 = 3'b010;
    bus.mem_addr_lo = 2'd0;
    bus.mem_rd_index = 5'd12;
    bus.mem_reg_write = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    chk("mr_busy", bus.mem_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_ready", bus.mem_ready, 1);
    chk("mr_rst_outs", {bus.wb_en, bus.load_err, bus.rd_index}, 0);
    chk("mr_rst_data", bus.wb_data, 0);
    tick();
    rst_n = 1'b1;
    exp_data = '0;
    exp_rd = '0;
    chk("mr_rel_ready", bus.mem_ready, 1);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("mr_stale_outs", {bus.wb_en, bus.load_err, bus.rd_index}, 0);
    chk("mr_stale_data", bus.wb_data, 0);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      int kind;
      int waits;
      kind = int'($urandom % 10);
      waits = ($urandom % 8 == 0) ? TO : int'($urandom % TO);
      if (kind < 4) alu_op(5'($urandom), $urandom, 1'($urandom));
      else          load_op(3'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), waits, $urandom);
      if ($urandom % 2 == 1) idle_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: LOAD_TIMEOUT, default 16, max cycles spent in WAIT_LOAD before abort (legal range 2..255).
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset is asynchronous and active-low.
REQ-004 Port: mem_valid  in  1  MEM stage offers an instruction.
REQ-005 Port: mem_ready  out  1  stage can accept; combinational, high exactly when state is IDLE.
REQ-006 Port: mem_reg_write  in  1  instruction writes a register.
REQ-007 Port: mem_is_load  in  1  instruction is a load.
REQ-008 Port: mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 Port: mem_addr_lo  in  2  low bits of the load address.
REQ-010 Port: mem_rd_index  in  5  destination register.
REQ-011 Port: mem_alu_result  in  32  non-load result.
REQ-012 Port: dmem_rvalid  in  1  data-memory read data valid.
REQ-013 Port: dmem_rdata  in  32  data-memory word, little-endian.
REQ-014 Port: wb_en  out  1  register-file write enable, one-cycle pulse per write.
REQ-015 Port: wb_data  out  32  register-file write data.
REQ-016 Port: rd_index  out  5  register-file write index.
REQ-017 Port: load_err  out  1  one-cycle pulse on misaligned, illegal, or timed-out load.

Function
REQ-018 The state machine SHALL have two states, IDLE and WAIT_LOAD.
REQ-019 An instruction SHALL be accepted on a rising edge where mem_valid && mem_ready.
REQ-020 A non-load accept SHALL register wb_en=mem_reg_write, wb_data=mem_alu_result and rd_index=mem_rd_index (one-cycle latency); the state stays IDLE, so back-to-back accepts are allowed.
REQ-021 A load accept SHALL latch funct3, addr_lo, rd_index and reg_write, clear the timeout counter, and enter WAIT_LOAD.
REQ-022 In WAIT_LOAD, dmem_rvalid=1 SHALL produce wb_en and extracted wb_data on the next cycle and return to IDLE.
REQ-023 Extraction SHALL select byte addr_lo, or halfword addr_lo[1]; LB and LH sign-extend, LBU and LHU zero-extend, and LW passes the full word.
REQ-024 dmem_rvalid SHALL be ignored in IDLE, including in the accept cycle.
REQ-025 Misalignment SHALL be detected at accept: LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or funct3 in {011,110,111}; the response SHALL be load_err=1 next cycle, no write, and state stays IDLE.
REQ-026 The counter SHALL increment each WAIT_LOAD cycle without rvalid; on reaching LOAD_TIMEOUT the block SHALL pulse load_err, perform no write, and return to IDLE.
REQ-027 wb_en SHALL be forced 0 when the destination is index 0 or reg_write=0; wb_data and rd_index still update.
REQ-028 wb_en and load_err SHALL be single-cycle pulses, and wb_data/rd_index SHALL hold their last value otherwise.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, counter 0, wb_en 0, load_err 0, wb_data 0, rd_index 0, and latched load fields 0.
REQ-030 A reset asserted during WAIT_LOAD SHALL abandon the load with no write; a later stale dmem_rvalid is ignored.
REQ-031 mem_ready SHALL be 1 during reset and in the first cycle after release.

Structure
REQ-032 The funct3 load encodings and the state encoding SHALL live in the shared cpu package.
REQ-033 Extraction SHALL be one combinational sub-module, load_align (inputs funct3, addr_lo, rdata; output data).
REQ-034 wb_stage SHALL contain only the FSM, counter, and output registers.

Verification
REQ-035 Non-load: ALU accept with rd=5, data 0x1234_5678 -> next cycle wb_en=1, rd_index=5, wb_data=0x1234_5678; a second accept immediately follows.
REQ-036 LB: addr_lo=3, rdata 0x80FF_0000 after 2 wait cycles -> wb_data=0xFFFF_FF80; same case as LBU -> 0x0000_0080.
REQ-037 LH: addr_lo=2, rdata 0x8001_0000 -> 0xFFFF_8001; LW: addr_lo=1 -> load_err pulse, wb_en=0, mem_ready stays 1.
REQ-038 Timeout: LOAD_TIMEOUT=16, load accepted, no rvalid -> load_err exactly 16 cycles after accept, no write, IDLE.
REQ-039 rd=0 load with rdata 0xDEAD_BEEF -> wb_en stays 0; rst_n pulsed mid-WAIT_LOAD then rvalid -> no write, all outputs 0.
